// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
// Optional feature macro used across this slice: MULDIV_UNSIGNED_EN.
package muldiv_pkg;

  localparam int WORD_W = 32;
  localparam int ITER_N = 32;
  localparam int CNT_W  = $clog2(ITER_N);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MULT = 3'd1,
    DIV  = 3'd2,
    WB   = 3'd3,
    DZ   = 3'd4
  } state_t;

  // Absolute value of a word, or the word itself when treated as unsigned.
  function automatic logic [WORD_W-1:0] magnitude(input logic [WORD_W-1:0] x,
                                                  input logic isUns);
    return (isUns || !x[WORD_W-1]) ? x : -x;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the control unit and the mul/div sequencer.
// With MULDIV_UNSIGNED_EN defined the bundle also carries op_unsigned.
//
// Handshake: start_mult/start_div are single-cycle requests that are taken
// only while busy is low (the sequencer is idle); a request seen while busy
// is high is dropped, not queued. a/b (and op_unsigned) are sampled on the
// accepting edge only. Completion is a one-cycle done pulse with hilo_write
// coincident; hi/lo are valid from that cycle until the next completion.
// A divide by zero completes with a one-cycle div_zero pulse instead of done.
interface muldiv_if;
  import muldiv_pkg::*;

  logic              start_mult;
  logic              start_div;
  logic [WORD_W-1:0] a;
  logic [WORD_W-1:0] b;
`ifdef MULDIV_UNSIGNED_EN
  logic              op_unsigned;
`endif
  logic              busy;
  logic              done;
  logic              hilo_write;
  logic              div_zero;
  logic [WORD_W-1:0] hi;
  logic [WORD_W-1:0] lo;

`ifdef MULDIV_UNSIGNED_EN
  modport master (output start_mult, start_div, a, b, op_unsigned,
                  input  busy, done, hilo_write, div_zero, hi, lo);
  modport slave  (input  start_mult, start_div, a, b, op_unsigned,
                  output busy, done, hilo_write, div_zero, hi, lo);
`else
  modport master (output start_mult, start_div, a, b,
                  input  busy, done, hilo_write, div_zero, hi, lo);
  modport slave  (input  start_mult, start_div, a, b,
                  output busy, done, hilo_write, div_zero, hi, lo);
`endif

endinterface

// File: rtl/muldiv_datapath.sv
// Shift-register datapath: radix-2 Booth multiply (shift-add when unsigned)
// and restoring division on magnitudes, plus the final sign fix-up into HI/LO.
// Register usage: accHi:accLo:qPrev is the Booth product register; for divide
// accHi[31:0] is the partial remainder and accLo the dividend/quotient.
module muldiv_datapath
  import muldiv_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              loadOp,
  input  logic              loadDiv,
  input  logic              loadUns,
  input  logic [WORD_W-1:0] opA,
  input  logic [WORD_W-1:0] opB,
  input  logic              step,
  input  logic              writeBack,
  output logic [WORD_W-1:0] hiOut,
  output logic [WORD_W-1:0] loOut
);

  logic [WORD_W:0]   accHi;
  logic [WORD_W-1:0] accLo;
  logic [WORD_W-1:0] mReg;
  logic              qPrev;
  logic              isDiv;
  logic              isUns;
  logic              negQ;
  logic              negR;

  logic [WORD_W:0]   mExt;
  logic [WORD_W:0]   boothSum;
  logic [WORD_W:0]   shiftRem;
  logic [WORD_W+1:0] trial;
  logic [WORD_W:0]   accHiNext;
  logic [WORD_W-1:0] accLoNext;
  logic              qPrevNext;
  logic [WORD_W-1:0] remFix;
  logic [WORD_W-1:0] quoFix;

  // One iteration of the active algorithm, plus the signed result fix-up.
  always_comb begin
    mExt      = isUns ? {1'b0, mReg} : {mReg[WORD_W-1], mReg};
    boothSum  = accHi;
    shiftRem  = {accHi[WORD_W-1:0], accLo[WORD_W-1]};
    trial     = {1'b0, shiftRem} - {2'b00, mReg};
    accHiNext = accHi;
    accLoNext = accLo;
    qPrevNext = qPrev;
    if (isUns) begin
      if (accLo[0]) boothSum = accHi + mExt;
    end else begin
      case ({accLo[0], qPrev})
        2'b01:   boothSum = accHi + mExt;
        2'b10:   boothSum = accHi - mExt;
        default: boothSum = accHi;
      endcase
    end
    if (isDiv) begin
      accHiNext = trial[WORD_W+1] ? shiftRem : trial[WORD_W:0];
      accLoNext = {accLo[WORD_W-2:0], ~trial[WORD_W+1]};
      qPrevNext = 1'b0;
    end else begin
      // Unsigned carry lands in bit 32, so the shift-in is a plain zero.
      accHiNext = {(isUns ? 1'b0 : boothSum[WORD_W]), boothSum[WORD_W:1]};
      accLoNext = {boothSum[0], accLo[WORD_W-1:1]};
      qPrevNext = accLo[0];
    end
    remFix = negR ? -accHi[WORD_W-1:0] : accHi[WORD_W-1:0];
    quoFix = negQ ? -accLo : accLo;
  end

  // Operand load, per-iteration update and HI/LO write-back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      accHi <= '0;
      accLo <= '0;
      mReg  <= '0;
      qPrev <= 1'b0;
      isDiv <= 1'b0;
      isUns <= 1'b0;
      negQ  <= 1'b0;
      negR  <= 1'b0;
      hiOut <= '0;
      loOut <= '0;
    end else begin
      if (loadOp) begin
        accHi <= '0;
        qPrev <= 1'b0;
        isDiv <= loadDiv;
        isUns <= loadUns;
        if (loadDiv) begin
          accLo <= magnitude(opA, loadUns);
          mReg  <= magnitude(opB, loadUns);
          negQ  <= !loadUns && (opA[WORD_W-1] ^ opB[WORD_W-1]);
          negR  <= !loadUns && opA[WORD_W-1];
        end else begin
          accLo <= opB;
          mReg  <= opA;
          negQ  <= 1'b0;
          negR  <= 1'b0;
        end
      end else if (step) begin
        accHi <= accHiNext;
        accLo <= accLoNext;
        qPrev <= qPrevNext;
      end
      if (writeBack) begin
        hiOut <= isDiv ? remFix : accHi[WORD_W-1:0];
        loOut <= isDiv ? quoFix : accLo;
      end
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle signed multiply/divide sequencer (32 iterations + write-back).
// Define MULDIV_UNSIGNED_EN to add op_unsigned for multu/divu behaviour.
module muldiv_sequencer
  import muldiv_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  muldiv_if.slave bus,
  output state_t dbgState
);

  state_t            state;
  state_t            stateNext;
  logic [CNT_W-1:0]  iterCnt;
  logic              loadOp;
  logic              loadDiv;
  logic              step;
  logic              opUns;
  logic              doneQ;

`ifdef MULDIV_UNSIGNED_EN
  assign opUns = bus.op_unsigned;
`else
  assign opUns = 1'b0;
`endif

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next state and datapath controls; starts are honoured only in IDLE.
  always_comb begin
    stateNext = state;
    loadOp    = 1'b0;
    loadDiv   = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start_mult) begin
          stateNext = MULT;
          loadOp    = 1'b1;
        end else if (bus.start_div) begin
          if (bus.b == '0) begin
            stateNext = DZ;
          end else begin
            stateNext = DIV;
            loadOp    = 1'b1;
            loadDiv   = 1'b1;
          end
        end
      end
      MULT, DIV: begin
        step = 1'b1;
        if (iterCnt == CNT_W'(ITER_N - 1)) stateNext = WB;
      end
      WB:      stateNext = IDLE;
      DZ:      stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Iteration counter: cleared on load, wraps back to 0 after the last step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       iterCnt <= '0;
    else if (loadOp) iterCnt <= '0;
    else if (step)   iterCnt <= iterCnt + 1'b1;
  end

  // done rises together with the HI/LO update made while leaving WB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) doneQ <= 1'b0;
    else       doneQ <= (state == WB);
  end

  muldiv_datapath u_datapath (
    .clk       (clk),
    .reset     (reset),
    .loadOp    (loadOp),
    .loadDiv   (loadDiv),
    .loadUns   (opUns),
    .opA       (bus.a),
    .opB       (bus.b),
    .step      (step),
    .writeBack (state == WB),
    .hiOut     (bus.hi),
    .loOut     (bus.lo)
  );

  assign bus.busy       = (state != IDLE);
  assign bus.done       = doneQ;
  assign bus.hilo_write = doneQ;
  assign bus.div_zero   = (state == DZ);
  assign dbgState       = state;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed corner cases plus
// randomized operations compared against an arithmetic reference model.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic   clk;
  logic   reset;
  state_t dbgState;
  int     totalCnt = 0;
  int     badCnt   = 0;
  logic [63:0] expQ[$];

  muldiv_if bus ();

  muldiv_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .dbgState (dbgState)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    totalCnt++;
    if (got !== exp) begin
      badCnt++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model straight from the arithmetic definition: {hi, lo}.
  function automatic logic [63:0] refModel(input bit isDiv, input bit uns,
                                           input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy, q, r, p;
    longint unsigned ux, uy;
    logic [63:0]     res;
    if (uns) begin
      ux = {32'h0, x};
      uy = {32'h0, y};
      if (isDiv) begin
        q = longint'(ux / uy);
        r = longint'(ux % uy);
        res = {r[31:0], q[31:0]};
      end else begin
        res = ux * uy;
      end
    end else begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      if (isDiv) begin
        q = sx / sy;
        r = sx % sy;
        res = {r[31:0], q[31:0]};
      end else begin
        p = sx * sy;
        res = p;
      end
    end
    return res;
  endfunction

  // ---------------- driver ----------------
  // Called at a falling edge; returns at a falling edge one cycle after done.
  task automatic runOp(input bit isDiv, input bit uns, input logic [31:0] x,
                       input logic [31:0] y, input bit pokeMid, output logic [63:0] result);
    int          cycles;
    logic [63:0] expVal;
    expQ.push_back(refModel(isDiv, uns, x, y));
    bus.a          = x;
    bus.b          = y;
    bus.start_mult = !isDiv;
    bus.start_div  = isDiv;
`ifdef MULDIV_UNSIGNED_EN
    bus.op_unsigned = uns;
`endif
    @(negedge clk);
    bus.start_mult = 1'b0;
    bus.start_div  = 1'b0;
    bus.a          = $urandom;
    bus.b          = $urandom;
`ifdef MULDIV_UNSIGNED_EN
    bus.op_unsigned = ~uns;
`endif
    checkVal("busyStart", bus.busy, 1);
    cycles = 0;
    while (!bus.done && cycles < 40) begin
      bus.start_mult = pokeMid && (cycles == 5);
      @(negedge clk);
      cycles++;
    end
    bus.start_mult = 1'b0;
    checkVal("latency", cycles, 33);
    checkVal("hiloWrite", bus.hilo_write, 1);
    checkVal("busyDone", bus.busy, 0);
    expVal = expQ.pop_front();
    result = {bus.hi, bus.lo};
    checkVal("result", result, expVal);
    @(negedge clk);
    checkVal("donePulse", bus.done, 0);
    checkVal("hiloHold", {bus.hi, bus.lo}, expVal);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] corners[6];
  logic [63:0] res;

  initial begin
    logic [31:0] x, y;
    bit          isDiv, uns, sawDone;

    corners[0] = 32'h8000_0000;
    corners[1] = 32'hFFFF_FFFF;
    corners[2] = 32'h0000_0001;
    corners[3] = 32'h7FFF_FFFF;
    corners[4] = 32'h0000_0000;
    corners[5] = 32'hFFFF_FFFE;

    reset          = 1'b1;
    bus.start_mult = 1'b0;
    bus.start_div  = 1'b0;
    bus.a          = '0;
    bus.b          = '0;
`ifdef MULDIV_UNSIGNED_EN
    bus.op_unsigned = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checkVal("rstBusy", bus.busy, 0);
    checkVal("rstDone", bus.done, 0);
    checkVal("rstDivZero", bus.div_zero, 0);
    checkVal("rstHiLo", {bus.hi, bus.lo}, 64'h0);
    checkVal("rstState", dbgState, IDLE);
    reset = 1'b0;

    // Directed: signed products including the most-negative square.
    runOp(0, 0, 32'd7, 32'hFFFF_FFFD, 0, res);
    checkVal("mul7xM3", res, 64'hFFFF_FFFF_FFFF_FFEB);
    runOp(0, 0, 32'h8000_0000, 32'h8000_0000, 0, res);
    checkVal("mulMinSq", res, 64'h4000_0000_0000_0000);

    // Directed: -7/2 with an ignored start_mult mid-operation.
    runOp(1, 0, 32'hFFFF_FFF9, 32'd2, 1, res);
    checkVal("divM7by2", res, 64'hFFFF_FFFF_FFFF_FFFD);

    // Directed: overflow-style divide must not raise an exception.
    runOp(1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 0, res);
    checkVal("divMinByM1", res, 64'h0000_0000_8000_0000);

    // Divide by zero: preload hi=0x11, lo=0x22 via 0x451 / 0x20.
    runOp(1, 0, 32'h451, 32'h20, 0, res);
    bus.a         = 32'd5;
    bus.b         = 32'd0;
    bus.start_div = 1'b1;
    @(negedge clk);
    bus.start_div = 1'b0;
    checkVal("dzPulse", bus.div_zero, 1);
    checkVal("dzBusy", bus.busy, 1);
    checkVal("dzDoneLow", bus.done, 0);
    @(negedge clk);
    checkVal("dzPulseEnd", bus.div_zero, 0);
    checkVal("dzIdle", bus.busy, 0);
    sawDone = bus.done;
    repeat (4) begin
      @(negedge clk);
      if (bus.done) sawDone = 1'b1;
    end
    checkVal("dzNoDone", sawDone, 0);
    checkVal("dzHiLo", {bus.hi, bus.lo}, 64'h0000_0011_0000_0022);

    // Reset 10 cycles into a multiply, then a divide right after release.
    bus.a          = 32'h1234_5678;
    bus.b          = 32'h0BAD_F00D;
    bus.start_mult = 1'b1;
    @(negedge clk);
    bus.start_mult = 1'b0;
    repeat (9) @(negedge clk);
    checkVal("midBusy", bus.busy, 1);
    reset = 1'b1;
    #1;
    checkVal("midRstBusy", bus.busy, 0);
    checkVal("midRstHiLo", {bus.hi, bus.lo}, 64'h0);
    checkVal("midRstState", dbgState, IDLE);
    @(negedge clk);
    reset = 1'b0;
    runOp(1, 0, 32'd9, 32'd3, 0, res);
    checkVal("div9by3", res, 64'h0000_0000_0000_0003);

`ifdef MULDIV_UNSIGNED_EN
    runOp(1, 1, 32'hFFFF_FFFF, 32'd2, 0, res);
    checkVal("divuMax", res, 64'h0000_0001_7FFF_FFFF);
    runOp(0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, res);
    checkVal("multuMax", res, 64'hFFFF_FFFE_0000_0001);
`endif

    // Randomized operations mixing corner values and random words.
    for (int i = 0; i < 24; i++) begin
      isDiv = 1'($urandom_range(0, 1));
      uns   = 1'b0;
`ifdef MULDIV_UNSIGNED_EN
      uns   = 1'($urandom_range(0, 1));
`endif
      x = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      case ($urandom_range(0, 3))
        0:       y = corners[$urandom_range(0, 5)];
        1:       y = 32'($urandom_range(1, 300));
        default: y = $urandom;
      endcase
      if (isDiv && y == 32'h0) y = 32'd3;
      runOp(isDiv, uns, x, y, 1'($urandom_range(0, 1)), res);
    end

    checkVal("queueEmpty", expQ.size(), 0);
    $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 start_mult  input  1  one-cycle request: signed multiply of a by b.
REQ-004 start_div  input  1  one-cycle request: signed divide of a by b.
REQ-005 a  input  32  operand A (multiplicand / dividend), sampled only on accepted start.
REQ-006 b  input  32  operand B (multiplier / divisor), sampled only on accepted start.
REQ-007 busy  output  1  high while an operation is in progress.
REQ-008 done  output  1  one-cycle pulse when hi/lo are updated.
REQ-009 hilo_write  output  1  one-cycle pulse, coincident with done, that writes the datapath HI/LO registers.
REQ-010 hi  output  32  multiply upper word / divide remainder.
REQ-011 lo  output  32  multiply lower word / divide quotient.
REQ-012 div_zero  output  1  one-cycle pulse: divide-by-zero exception to the control unit.

Function
REQ-013 The FSM SHALL have states IDLE, MULT, DIV, WB and DZ.
REQ-014 A start SHALL be accepted only in IDLE; starts in any other state SHALL be ignored.
REQ-015 If start_mult and start_div are high in the same IDLE cycle, multiply SHALL win.
REQ-016 An accepted start SHALL capture a and b; operand changes while busy SHALL have no effect.
REQ-017 The block SHALL use a 5-bit iteration counter and run exactly 32 iterations: MULT as radix-2 Booth, DIV as restoring division on magnitudes. After the last iteration it SHALL enter WB.
REQ-018 WB SHALL last one cycle, assert done and hilo_write, update hi/lo and then return to IDLE.
REQ-019 Latency: a start accepted at edge 0 SHALL give done high during the cycle after edge 33.
REQ-020 busy SHALL be high in MULT, DIV, WB and DZ, and low in IDLE.
REQ-021 Multiply SHALL produce the full 64-bit two's-complement product: {hi,lo}.
REQ-022 Divide SHALL truncate the quotient toward zero; the remainder sign SHALL equal the dividend sign; lo = quotient, hi = remainder.
REQ-023 Divide 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0, with no exception.
REQ-024 If b==0 on an accepted start_div, the FSM SHALL enter DZ for one cycle: div_zero high, no iterations, hi/lo unchanged, done low, then IDLE.
REQ-025 hi/lo SHALL hold their values between WB cycles.

Reset
REQ-026 Asserting reset SHALL force IDLE immediately, including mid-operation. It SHALL clear the counter, internal accumulators, hi and lo to 0, and drive busy, done, hilo_write and div_zero to 0.
REQ-027 After reset deasserts, a start SHALL be accepted at the first rising edge.

Configuration
REQ-028 Macro MULDIV_UNSIGNED_EN SHALL add input op_unsigned (1 bit), sampled with start.
- op_unsigned=1: operands treated as unsigned (multu/divu); sign handling bypassed.
REQ-029 Without MULDIV_UNSIGNED_EN:
- op_unsigned port absent;
- all operations signed.

Structure
REQ-030 Package muldiv_pkg SHALL hold:
- the FSM state enum;
- constants WORD_W=32 and ITER_N=32.
REQ-031 Sub-module muldiv_datapath SHALL hold the Booth/restoring shift registers and sign fix-up, controlled by the FSM in muldiv_sequencer.

Verification
REQ-032 mult a=7, b=0xFFFFFFFD (-3) -> edge 33: done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-033 mult a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-034 div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; a start_mult pulsed mid-operation is ignored.
REQ-035 div a=5, b=0 (hi/lo preloaded 0x11/0x22) -> div_zero pulse the cycle after start; done never asserted; hi=0x11, lo=0x22.
REQ-036 reset asserted 10 cycles into a mult -> busy=0, hi=lo=0 immediately; after release, start_div a=9, b=3 -> lo=3, hi=0.
REQ-037 MULDIV_UNSIGNED_EN, op_unsigned=1, div a=0xFFFFFFFF, b=2 -> lo=0x7FFFFFFF, hi=1.
